store_buffer: RTL and testbench

Posted-store FIFO between the MEM pipeline stage and the byte-addressable data memory. Stores retire into the buffer in one cycle and drain to memory in program order whenever the single memory port is not serving a load. Loads own the port with priority. A load whose byte range overlaps a buffered store is stalled until that store drains, or is forwarded when the optional forwarding feature is compiled in.

---
 rtl/store_buffer_if.sv | 34 +++
 rtl/store_buffer.sv | 183 ++++++++++++++++++
 tb/tb_store_buffer.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// store_buffer_if: MEM-stage store/load handshake plus the single data-memory
// port driven by the store buffer. The master side is the pipeline, the slave
// side is the buffer.
interface store_buffer_if;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [2:0]  st_func3;
  logic [31:0] st_data;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [2:0]  ld_func3;
  logic        ld_stall;
  logic        ld_fwd_valid;
  logic [31:0] ld_fwd_data;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [2:0]  mem_func3;
  logic [31:0] mem_wdata;
  logic        empty;

  modport master (
    output st_valid, st_addr, st_func3, st_data, ld_valid, ld_addr, ld_func3,
    input  st_ready, ld_stall, ld_fwd_valid, ld_fwd_data,
    input  mem_read, mem_write, mem_addr, mem_func3, mem_wdata, empty
  );

  modport slave (
    input  st_valid, st_addr, st_func3, st_data, ld_valid, ld_addr, ld_func3,
    output st_ready, ld_stall, ld_fwd_valid, ld_fwd_data,
    output mem_read, mem_write, mem_addr, mem_func3, mem_wdata, empty
  );
endinterface

// File: rtl/store_buffer.sv
// store_buffer: posted-store FIFO between the MEM stage and the data memory.
// Stores retire in one cycle and drain in program order whenever no load owns
// the memory port. Loads overlapping a buffered store stall until it drains.
// Optional feature macro: STBUF_FWD_EN (word-exact store-to-load forwarding).
// Outputs are combinational from inputs and state; while rst is high they are
// forced to their reset values.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  store_buffer_if.slave bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [31:0]      ent_addr_r  [DEPTH];
  logic [2:0]       ent_func3_r [DEPTH];
  logic [31:0]      ent_data_r  [DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;

  logic             hazard_s;
  logic             fwd_s;
  logic             enq_s;
  logic             drain_s;
`ifdef STBUF_FWD_EN
  logic [PTR_W-1:0] young_s;
`endif

  logic             st_ready_s;
  logic             ld_stall_s;
  logic             ld_fwd_valid_s;
  logic [31:0]      ld_fwd_data_s;
  logic             mem_read_s;
  logic             mem_write_s;
  logic [31:0]      mem_addr_s;
  logic [2:0]       mem_func3_s;
  logic [31:0]      mem_wdata_s;
  logic             empty_s;

  // Last byte address of an access; 33 bits so ranges never wrap past 0xFFFFFFFF.
  function automatic logic [32:0] range_hi(input logic [31:0] addr, input logic [1:0] size_code);
    case (size_code)
      2'b00:   range_hi = {1'b0, addr};
      2'b01:   range_hi = {1'b0, addr} + 33'd1;
      default: range_hi = {1'b0, addr} + 33'd3;
    endcase
  endfunction

  // True when the two byte ranges share at least one byte.
  function automatic logic overlaps(input logic [31:0] a_addr, input logic [1:0] a_size,
                                    input logic [31:0] b_addr, input logic [1:0] b_size);
    overlaps = ({1'b0, a_addr} <= range_hi(b_addr, b_size)) &&
               ({1'b0, b_addr} <= range_hi(a_addr, a_size));
  endfunction

  // Scan every valid entry (head included) for overlap with the presented load,
  // remembering the youngest overlapping entry for forwarding.
  always_comb begin
    logic [PTR_W-1:0] idx_v;
    logic             hit_v;
    hazard_s = 1'b0;
    idx_v    = head_r;
    hit_v    = 1'b0;
`ifdef STBUF_FWD_EN
    young_s  = head_r;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx_v    = head_r + PTR_W'(i);
      hit_v    = bus.ld_valid && (CNT_W'(i) < count_r) &&
                 overlaps(ent_addr_r[idx_v], ent_func3_r[idx_v][1:0],
                          bus.ld_addr, bus.ld_func3[1:0]);
      hazard_s = hazard_s | hit_v;
`ifdef STBUF_FWD_EN
      young_s  = hit_v ? idx_v : young_s;
`endif
    end
  end

`ifdef STBUF_FWD_EN
  // Forward only when the youngest overlap is an identical aligned word access.
  always_comb begin
    fwd_s = hazard_s &&
            (ent_func3_r[young_s] == 3'b010) &&
            (ent_addr_r[young_s] == bus.ld_addr) &&
            (bus.ld_func3 == 3'b010);
  end
`else
  assign fwd_s = 1'b0;
`endif

  // Memory port arbitration (loads first) and handshake outputs.
  always_comb begin
    st_ready_s     = 1'b1;
    empty_s        = 1'b1;
    ld_stall_s     = 1'b0;
    ld_fwd_valid_s = 1'b0;
    ld_fwd_data_s  = 32'h0000_0000;
    mem_read_s     = 1'b0;
    mem_write_s    = 1'b0;
    mem_addr_s     = 32'h0000_0000;
    mem_func3_s    = 3'b000;
    mem_wdata_s    = 32'h0000_0000;
    enq_s          = 1'b0;
    drain_s        = 1'b0;
    if (rst) begin
      st_ready_s = 1'b1;
      empty_s    = 1'b1;
    end else begin
      st_ready_s     = (count_r < DEPTH_C);
      empty_s        = (count_r == {CNT_W{1'b0}});
      ld_stall_s     = bus.ld_valid && hazard_s && !fwd_s;
      ld_fwd_valid_s = fwd_s;
`ifdef STBUF_FWD_EN
      ld_fwd_data_s  = fwd_s ? ent_data_r[young_s] : 32'h0000_0000;
`endif
      // Unsupported store sizes complete the handshake but are dropped.
      enq_s          = bus.st_valid && st_ready_s &&
                       ((bus.st_func3 == 3'b000) || (bus.st_func3 == 3'b001) ||
                        (bus.st_func3 == 3'b010));
      if (bus.ld_valid && !hazard_s) begin
        mem_read_s  = 1'b1;
        mem_addr_s  = bus.ld_addr;
        mem_func3_s = bus.ld_func3;
      end else if (count_r != {CNT_W{1'b0}}) begin
        mem_write_s = 1'b1;
        drain_s     = 1'b1;
        mem_addr_s  = ent_addr_r[head_r];
        mem_func3_s = ent_func3_r[head_r];
        mem_wdata_s = ent_data_r[head_r];
      end else begin
        mem_read_s  = 1'b0;
        mem_write_s = 1'b0;
      end
    end
  end

  // Head/tail pointers and occupancy count.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (enq_s) begin
        tail_r <= tail_r + PTR_W'(1);
      end
      if (drain_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      case ({enq_s, drain_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; validity comes from head/count, so the payload needs no reset.
  always_ff @(posedge clk) begin
    if (enq_s) begin
      ent_addr_r[tail_r]  <= bus.st_addr;
      ent_func3_r[tail_r] <= bus.st_func3;
      ent_data_r[tail_r]  <= bus.st_data;
    end
  end

  assign bus.st_ready     = st_ready_s;
  assign bus.empty        = empty_s;
  assign bus.ld_stall     = ld_stall_s;
  assign bus.ld_fwd_valid = ld_fwd_valid_s;
  assign bus.ld_fwd_data  = ld_fwd_data_s;
  assign bus.mem_read     = mem_read_s;
  assign bus.mem_write    = mem_write_s;
  assign bus.mem_addr     = mem_addr_s;
  assign bus.mem_func3    = mem_func3_s;
  assign bus.mem_wdata    = mem_wdata_s;

endmodule

// File: tb/tb_store_buffer.sv
// tb_store_buffer: directed scenarios plus randomized traffic checked against a
// queue-based reference model of the store buffer.
module tb_store_buffer;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  store_buffer_if bus();

  store_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit allow_dual = 1'b0;

  // The pipeline never presents a store and a load together, except where a
  // scenario deliberately holds a load to keep stores from draining.
  assert property (@(posedge clk) disable iff (allow_dual || rst) !(bus.st_valid && bus.ld_valid));

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] a;
    logic [2:0]  f;
    logic [31:0] d;
  } ent_t;
  ent_t q[$];

  logic        e_st_ready, e_empty, e_stall, e_fwd_valid, e_read, e_write;
  logic [31:0] e_fwd_data, e_addr, e_wdata;
  logic [2:0]  e_func3;

  function automatic longint unsigned nbytes(input logic [2:0] f);
    case (f[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit ranges_meet(input logic [31:0] a1, input logic [2:0] f1,
                                     input logic [31:0] a2, input logic [2:0] f2);
    longint unsigned lo1, hi1, lo2, hi2;
    lo1 = a1; hi1 = lo1 + nbytes(f1) - 1;
    lo2 = a2; hi2 = lo2 + nbytes(f2) - 1;
    return (lo1 <= hi2) && (lo2 <= hi1);
  endfunction

  task automatic model_expect();
    bit hz, fw;
    int yi;
    hz = 1'b0; fw = 1'b0; yi = -1;
    if (bus.ld_valid) begin
      foreach (q[i]) begin
        if (ranges_meet(q[i].a, q[i].f, bus.ld_addr, bus.ld_func3)) begin
          hz = 1'b1;
          yi = i;
        end
      end
    end
`ifdef STBUF_FWD_EN
    if (hz && q[yi].f == 3'b010 && q[yi].a == bus.ld_addr && bus.ld_func3 == 3'b010) fw = 1'b1;
`endif
    if (rst) begin
      e_st_ready = 1'b1; e_empty = 1'b1; e_stall = 1'b0; e_fwd_valid = 1'b0;
      e_fwd_data = 32'h0; e_read = 1'b0; e_write = 1'b0;
      e_addr = 32'h0; e_func3 = 3'b000; e_wdata = 32'h0;
    end else begin
      e_st_ready  = (q.size() < DEPTH);
      e_empty     = (q.size() == 0);
      e_stall     = bus.ld_valid && hz && !fw;
      e_fwd_valid = fw;
      e_fwd_data  = fw ? q[yi].d : 32'h0;
      e_read      = bus.ld_valid && !hz;
      e_write     = !e_read && (q.size() > 0);
      e_addr      = e_read ? bus.ld_addr  : (e_write ? q[0].a : 32'h0);
      e_func3     = e_read ? bus.ld_func3 : (e_write ? q[0].f : 3'b000);
      e_wdata     = e_write ? q[0].d : 32'h0;
    end
  endtask

  task automatic model_update();
    bit enq;
    model_expect();
    if (rst) begin
      q.delete();
    end else begin
      enq = bus.st_valid && (q.size() < DEPTH) && (bus.st_func3 inside {3'b000, 3'b001, 3'b010});
      if (e_write) void'(q.pop_front());
      if (enq) q.push_back('{a: bus.st_addr, f: bus.st_func3, d: bus.st_data});
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic sv, input logic [31:0] sa, input logic [2:0] sf, input logic [31:0] sd,
                       input logic lv, input logic [31:0] la, input logic [2:0] lf);
    bus.st_valid = sv; bus.st_addr = sa; bus.st_func3 = sf; bus.st_data = sd;
    bus.ld_valid = lv; bus.ld_addr = la; bus.ld_func3 = lf;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 3'b000, 32'h0, 1'b0, 32'h0, 3'b000);
  endtask

  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, 32'h100, 3'b010, 32'h1111_1111, 1'b0, 32'h0, 3'b000);
    @(negedge clk); advance();
    drive(1'b1, 32'h104, 3'b010, 32'h2222_2222, 1'b0, 32'h0, 3'b000);
    @(negedge clk); advance();
    // One entry (0x104) is still buffered; assert reset with an overlapping load.
    rst = 1'b1;
    drive(1'b0, 32'h0, 3'b000, 32'h0, 1'b1, 32'h104, 3'b010);
    @(negedge clk);
    checks++;
    if ({bus.st_ready, bus.empty, bus.ld_stall, bus.ld_fwd_valid} !== 4'b1100) begin
      failures++;
      $display("FAIL reset_flags got rdy/empty/stall/fwd=%b want=1100",
               {bus.st_ready, bus.empty, bus.ld_stall, bus.ld_fwd_valid});
    end
    checks++;
    if ({bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_func3, bus.mem_wdata, bus.ld_fwd_data} !== 102'd0) begin
      failures++;
      $display("FAIL reset_mem got rd=%b wr=%b addr=%h f3=%b wd=%h fwd=%h want all zero",
               bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_func3, bus.mem_wdata, bus.ld_fwd_data);
    end
    advance();
    rst = 1'b0;
    idle();
    @(negedge clk);
    checks++;
    if ({bus.empty, bus.st_ready, bus.mem_write} !== 3'b110) begin
      failures++;
      $display("FAIL reset_after got empty/rdy/wr=%b want=110", {bus.empty, bus.st_ready, bus.mem_write});
    end
    advance();
  endtask

  task automatic test_fill_drain();
    logic [31:0] dat [4];
    allow_dual = 1'b1;
    for (int k = 0; k < 4; k++) begin
      dat[k] = $urandom;
      drive(1'b1, 32'(4 * k), 3'b010, dat[k], 1'b1, 32'h80, 3'b010);
      @(negedge clk);
      checks++;
      if ({bus.st_ready, bus.mem_read, bus.mem_write, bus.mem_addr} !== {1'b1, 1'b1, 1'b0, 32'h80}) begin
        failures++;
        $display("FAIL fill_%0d got rdy=%b rd=%b wr=%b addr=%h want rdy=1 rd=1 wr=0 addr=80",
                 k, bus.st_ready, bus.mem_read, bus.mem_write, bus.mem_addr);
      end
      advance();
    end
    drive(1'b0, 32'h0, 3'b000, 32'h0, 1'b1, 32'h80, 3'b010);
    @(negedge clk);
    checks++;
    if ({bus.st_ready, bus.empty, bus.mem_read} !== 3'b001) begin
      failures++;
      $display("FAIL full_flags got rdy/empty/rd=%b want=001", {bus.st_ready, bus.empty, bus.mem_read});
    end
    advance();
    allow_dual = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idle();
      @(negedge clk);
      checks++;
      if ({bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_func3, bus.mem_wdata} !==
          {1'b1, 1'b0, 32'(4 * k), 3'b010, dat[k]}) begin
        failures++;
        $display("FAIL drain_%0d got wr=%b rd=%b addr=%h f3=%b wd=%h want wr=1 rd=0 addr=%h f3=010 wd=%h",
                 k, bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_func3, bus.mem_wdata, 32'(4 * k), dat[k]);
      end
      if (k == 0) begin
        checks++;
        if (bus.st_ready !== 1'b0) begin
          failures++;
          $display("FAIL full_drain_ready got=%b want=0", bus.st_ready);
        end
      end
      advance();
    end
    idle();
    @(negedge clk);
    checks++;
    if ({bus.empty, bus.st_ready, bus.mem_write} !== 3'b110) begin
      failures++;
      $display("FAIL drained got empty/rdy/wr=%b want=110", {bus.empty, bus.st_ready, bus.mem_write});
    end
    advance();
  endtask

  task automatic test_hazard();
    drive(1'b1, 32'h11, 3'b000, 32'h0000_00AB, 1'b0, 32'h0, 3'b000);
    @(negedge clk); advance();
    drive(1'b0, 32'h0, 3'b000, 32'h0, 1'b1, 32'h10, 3'b010);
    @(negedge clk);
    checks++;
    if ({bus.ld_stall, bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata} !==
        {1'b1, 1'b0, 1'b1, 32'h11, 32'hAB}) begin
      failures++;
      $display("FAIL hazard_stall got stall=%b rd=%b wr=%b addr=%h wd=%h want 1 0 1 11 000000ab",
               bus.ld_stall, bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata);
    end
    advance();
    @(negedge clk);
    checks++;
    if ({bus.ld_stall, bus.mem_read, bus.mem_write, bus.mem_addr} !== {1'b0, 1'b1, 1'b0, 32'h10}) begin
      failures++;
      $display("FAIL hazard_release got stall=%b rd=%b wr=%b addr=%h want 0 1 0 10",
               bus.ld_stall, bus.mem_read, bus.mem_write, bus.mem_addr);
    end
    advance();
    idle(); @(negedge clk); advance();
  endtask

  task automatic test_no_false_hazard();
    drive(1'b1, 32'h20, 3'b010, 32'h1234_5678, 1'b0, 32'h0, 3'b000);
    @(negedge clk); advance();
    drive(1'b0, 32'h0, 3'b000, 32'h0, 1'b1, 32'h24, 3'b000);
    @(negedge clk);
    checks++;
    if ({bus.ld_stall, bus.mem_read, bus.mem_addr} !== {1'b0, 1'b1, 32'h24}) begin
      failures++;
      $display("FAIL adjacent_load got stall=%b rd=%b addr=%h want 0 1 24", bus.ld_stall, bus.mem_read, bus.mem_addr);
    end
    advance();
    drive(1'b0, 32'h0, 3'b000, 32'h0, 1'b1, 32'h23, 3'b000);
    @(negedge clk);
    checks++;
    if ({bus.ld_stall, bus.mem_write, bus.mem_addr} !== {1'b1, 1'b1, 32'h20}) begin
      failures++;
      $display("FAIL last_byte_hazard got stall=%b wr=%b addr=%h want 1 1 20", bus.ld_stall, bus.mem_write, bus.mem_addr);
    end
    advance();
    // A word ending past 0xFFFFFFFF must not alias onto address 0.
    drive(1'b1, 32'hFFFF_FFFE, 3'b010, 32'hCAFE_F00D, 1'b0, 32'h0, 3'b000);
    @(negedge clk); advance();
    drive(1'b0, 32'h0, 3'b000, 32'h0, 1'b1, 32'h0, 3'b000);
    @(negedge clk);
    checks++;
    if ({bus.ld_stall, bus.mem_read, bus.mem_addr} !== {1'b0, 1'b1, 32'h0}) begin
      failures++;
      $display("FAIL no_wrap got stall=%b rd=%b addr=%h want 0 1 0", bus.ld_stall, bus.mem_read, bus.mem_addr);
    end
    advance();
    idle(); @(negedge clk); advance();
  endtask

  task automatic test_forwarding();
    drive(1'b1, 32'h40, 3'b010, 32'hDEAD_BEEF, 1'b0, 32'h0, 3'b000);
    @(negedge clk); advance();
    drive(1'b0, 32'h0, 3'b000, 32'h0, 1'b1, 32'h40, 3'b010);
    @(negedge clk);
    checks++;
`ifdef STBUF_FWD_EN
    if ({bus.ld_fwd_valid, bus.ld_fwd_data, bus.ld_stall, bus.mem_read, bus.mem_write} !==
        {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL fwd_hit got fv=%b fd=%h stall=%b rd=%b wr=%b want 1 deadbeef 0 0 1",
               bus.ld_fwd_valid, bus.ld_fwd_data, bus.ld_stall, bus.mem_read, bus.mem_write);
    end
`else
    if ({bus.ld_fwd_valid, bus.ld_fwd_data, bus.ld_stall, bus.mem_write, bus.mem_addr} !==
        {1'b0, 32'h0, 1'b1, 1'b1, 32'h40}) begin
      failures++;
      $display("FAIL fwd_off_stall got fv=%b fd=%h stall=%b wr=%b addr=%h want 0 0 1 1 40",
               bus.ld_fwd_valid, bus.ld_fwd_data, bus.ld_stall, bus.mem_write, bus.mem_addr);
    end
`endif
    advance();
    @(negedge clk);
    checks++;
    if ({bus.ld_fwd_valid, bus.ld_stall, bus.mem_read, bus.mem_addr} !== {1'b0, 1'b0, 1'b1, 32'h40}) begin
      failures++;
      $display("FAIL fwd_after got fv=%b stall=%b rd=%b addr=%h want 0 0 1 40",
               bus.ld_fwd_valid, bus.ld_stall, bus.mem_read, bus.mem_addr);
    end
    advance();
    idle(); @(negedge clk); advance();
  endtask

  task automatic test_reset_mid_drain();
    allow_dual = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'(16 * k), 3'b010, $urandom, 1'b1, 32'h80, 3'b010);
      @(negedge clk); advance();
    end
    allow_dual = 1'b0;
    rst = 1'b1;
    idle();
    @(negedge clk);
    checks++;
    if ({bus.empty, bus.mem_write} !== 2'b10) begin
      failures++;
      $display("FAIL mid_reset got empty/wr=%b want=10", {bus.empty, bus.mem_write});
    end
    advance();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.empty, bus.mem_write} !== 2'b10) begin
        failures++;
        $display("FAIL post_reset_%0d got empty/wr=%b want=10", k, {bus.empty, bus.mem_write});
      end
      advance();
    end
  endtask

  task automatic test_random();
    logic [2:0]  st_f3_tab [8];
    logic [2:0]  ld_f3_tab [5];
    logic [104:0] got, want;
    bit          hold;
    logic [31:0] a;
    int          kind;
    st_f3_tab = '{3'b000, 3'b001, 3'b010, 3'b010, 3'b000, 3'b001, 3'b011, 3'b110};
    ld_f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    hold = 1'b0;
    for (int n = 0; n < 500; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      kind = $urandom_range(0, 9);
      a = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                      : 32'($urandom_range(0, 31));
      if (hold && !rst) begin
        // Stalled load is re-presented unchanged.
        bus.st_valid = 1'b0;
      end else if (kind < 4) begin
        drive(1'b1, a, st_f3_tab[$urandom_range(0, 7)], $urandom, 1'b0, 32'h0, 3'b000);
        if ($urandom_range(0, 1) == 1) begin
          bus.st_addr = a & 32'hFFFF_FFFC; bus.st_func3 = 3'b010;
        end
      end else if (kind < 8) begin
        drive(1'b0, 32'h0, 3'b000, 32'h0, 1'b1, a, ld_f3_tab[$urandom_range(0, 4)]);
        if ($urandom_range(0, 1) == 1) begin
          bus.ld_addr = a & 32'hFFFF_FFFC; bus.ld_func3 = 3'b010;
        end
      end else begin
        idle();
      end
      @(negedge clk);
      model_expect();
      got  = {bus.st_ready, bus.empty, bus.ld_stall, bus.ld_fwd_valid, bus.ld_fwd_data,
              bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_func3, bus.mem_wdata};
      want = {e_st_ready, e_empty, e_stall, e_fwd_valid, e_fwd_data,
              e_read, e_write, e_addr, e_func3, e_wdata};
      checks++;
      if (got !== want) begin
        failures++;
        $display("FAIL random_cycle_%0d got=%h want=%h (rdy,empty,stall,fv,fd,rd,wr,addr,f3,wd)", n, got, want);
      end
      hold = e_stall;
      advance();
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    @(negedge clk);
    advance();
    rst = 1'b0;
    test_reset();
    test_fill_drain();
    test_hazard();
    test_no_false_hazard();
    test_forwarding();
    test_reset_mid_drain();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
